// File: rtl/strobe_capture_pkg.sv
// Shared types and helpers for the strobe capture bank.
// Holds the readback state enum, default sizes and the pointer-width helper.
package strobe_capture_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHANNELS = 4;

  typedef enum logic {
    IDLE,
    SHIFT
  } rd_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-load, serial-out shifter, MSB first.
// Emits W bits on the W cycles after load; busy covers exactly that window.
module piso_shifter
  import strobe_capture_pkg::*;
#(
  parameter int W = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         dout,
  output logic         busy
);

  localparam int CW = clog2_min1(W);

  rd_state_t   state;
  rd_state_t   state_nx;
  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy = 1'b0;
    dout = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        dout = sr[W-1];
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (load) sr <= din;
      cnt <= '0;
    end else begin
      sr  <= sr << 1;
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/strobe_capture_bank.sv
// Strobe-gated serial capture into a round-robin bank with serial readback.
// Define STROBE_CAPTURE_PARITY_EN to store and shift out an even-parity bit.
module strobe_capture_bank
  import strobe_capture_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               CHANNELS  = DEF_CHANNELS,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CH_W      = clog2_min1(CHANNELS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stb,
  input  logic            di,
  input  logic            rd_stb,
  input  logic [CH_W-1:0] rd_ch,
  output logic            dout,
  output logic            busy,
  output logic            commit,
  output logic [CH_W-1:0] wr_ptr,
  output logic            rd_err
);

`ifdef STROBE_CAPTURE_PARITY_EN
  localparam int BW = WIDTH + 1;
  localparam logic [BW-1:0] RST_ENTRY = {RESET_VAL, ^RESET_VAL};
`else
  localparam int BW = WIDTH;
  localparam logic [BW-1:0] RST_ENTRY = RESET_VAL;
`endif
  localparam int CNT_W = clog2_min1(WIDTH);

  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] cnt;
  logic [BW-1:0]    bank [CHANNELS];
  logic [BW-1:0]    entry;
  logic [BW-1:0]    rd_word;
  logic             done;
  logic             load;
  logic             bad_ch;

  assign word = {sr, di};
  assign done = stb && (cnt == CNT_W'(WIDTH - 1));

`ifdef STROBE_CAPTURE_PARITY_EN
  assign entry = {word, ^word};
`else
  assign entry = word;
`endif

  assign load    = rd_stb && !busy;
  assign bad_ch  = int'(rd_ch) >= CHANNELS;
  // Bank is sampled before this edge's commit lands: read-before-write.
  assign rd_word = bad_ch ? '0 : bank[rd_ch];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      cnt    <= '0;
      wr_ptr <= '0;
      commit <= 1'b0;
      rd_err <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        bank[i] <= RST_ENTRY;
      end
    end else begin
      commit <= done;
      if (load && bad_ch) rd_err <= 1'b1;
      if (stb) begin
        sr  <= word[WIDTH-2:0];
        cnt <= done ? '0 : cnt + CNT_W'(1);
      end
      if (done) begin
        bank[wr_ptr] <= entry;
        wr_ptr <= (wr_ptr == CH_W'(CHANNELS - 1)) ? '0
                                                  : wr_ptr + CH_W'(1);
      end
    end
  end

  piso_shifter #(
    .W(BW)
  ) u_rd (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .din  (rd_word),
    .dout (dout),
    .busy (busy)
  );

endmodule

// File: doc/strobe_capture_bank.md
Name: strobe_capture_bank

Overview:
Parametrised successor to the single-bit strobe-gated capture register used in fuzzer top-levels.
- Serially captures strobe-qualified data into a WIDTH-bit shift register.
- Commits each completed word round-robin into one of CHANNELS bank registers.
- Serially reads back any selected channel on a single output pin.
- Gives fuzzers a compact, pin-light design exercising FF/CE/SR fabric with controllable width and depth.

Parameters:
- WIDTH, 8: bits per captured word; legal range 2..64.
- CHANNELS, 4: number of bank registers; legal range 1..16.
- RESET_VAL, 0: WIDTH-bit value loaded into every bank entry on reset.
- CH_W, max(1,$clog2(CHANNELS)): derived width of channel pointers/selects; not user-overridden.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stb  input  1  capture strobe; di is sampled only when stb=1.
- di  input  1  serial capture data, MSB first.
- rd_stb  input  1  readback request.
- rd_ch  input  CH_W  channel selected for readback, sampled with rd_stb.
- do  output  1  serial readback data, MSB first.
- busy  output  1  high while readback is shifting.
- commit  output  1  one-cycle pulse on the cycle after a word is committed.
- wr_ptr  output  CH_W  channel that the next completed word will be written to.
- rd_err  output  1  sticky flag, set when rd_ch >= CHANNELS at an accepted rd_stb.

Behaviour:
Reset (rst_n=0, asynchronous):
- Capture shift register and bit counter cnt are 0.
- Every bank entry is RESET_VAL.
- wr_ptr=0, do=0, busy=0, commit=0, rd_err=0.
- Reset asserted mid-capture or mid-readback aborts the operation; no partial commit.

Capture path:
- On an edge with stb=1: sr <= {sr[WIDTH-2:0], di}; cnt <= cnt+1.
- On the edge with stb=1 and cnt==WIDTH-1:
  - bank[wr_ptr] <= {sr[WIDTH-2:0], di}.
  - cnt <= 0.
  - wr_ptr <= (wr_ptr==CHANNELS-1) ? 0 : wr_ptr+1.
  - commit goes high for exactly the following cycle.
- stb=0 holds all capture state; gaps between strobes are allowed.
- Capture operates independently of readback; capture proceeds while busy.

Readback FSM (states IDLE, SHIFT):
- IDLE:
  - rd_stb=1 loads out_sr with bank[rd_ch], or all-zero if rd_ch >= CHANNELS (which also sets rd_err).
  - Transition to SHIFT; busy=1 from the next cycle.
  - do presents out_sr MSB from the next cycle.
- SHIFT:
  - Each cycle shifts out_sr left by one; do = current MSB.
  - After WIDTH data cycles, return to IDLE; busy=0 and do=0.
- rd_stb while busy is ignored (not queued).
- Read/write collision: rd_stb accepted on the same edge that commits to the same channel returns the OLD value (read-before-write).
- Latency: rd_stb edge to first data bit on do is 1 cycle; total busy window is WIDTH cycles.
- rd_err clears only on reset.

Optional Feature:
STROBE_CAPTURE_PARITY_EN
- Defined:
  - Each bank entry stores an extra even-parity bit computed from the committed word.
  - Readback shifts WIDTH data bits, then the parity bit, so busy lasts WIDTH+1 cycles.
- Undefined: no parity storage; readback is WIDTH cycles as above.

Decomposition:
- Shared package strobe_capture_pkg holds:
  - Readback state enum (IDLE, SHIFT).
  - The clog2-with-minimum-1 helper function used for CH_W.
  - Default WIDTH/CHANNELS constants.
- One natural sub-module, piso_shifter: parallel-load serial-out shift register with its own count and busy. It is instantiated once for readback; WIDTH is widened by 1 under the parity macro.

Test Plan:
- Reset and first capture: WIDTH=8, CHANNELS=4. Strobe in 0xA5 MSB-first → commit pulses once, bank[0]=0xA5, wr_ptr=1. Then rd_stb with rd_ch=0 → do emits 1,0,1,0,0,1,0,1 over 8 cycles, busy high for exactly 8 cycles.
- Wrap-around: commit 5 words 0x11,0x22,0x33,0x44,0x55 → bank[0]=0x55, bank[1..3]=0x22,0x33,0x44, wr_ptr=1.
- Gapped strobes: 0x3C with random stb=0 gaps of 0..5 cycles between bits → bank entry 0x3C, commit exactly once.
- Collision: rd_stb with rd_ch=wr_ptr on the same edge as the final capture bit of 0xFF, where the old bank value is 0x00 → reads 0x00; a subsequent read returns 0xFF.
- Error/ignore: CHANNELS=3, rd_stb with rd_ch=3 → do all zeros, rd_err=1 and sticky. A second rd_stb while busy is ignored (busy length unchanged).
- Reset mid-operation: assert rst_n=0 after 4 capture bits and 3 readback bits → all outputs at reset values immediately. The next full capture lands in bank[0]. With STROBE_CAPTURE_PARITY_EN defined, reading 0x07 yields a trailing parity bit of 1 and a 9-cycle busy.
